fb_addr_gen: RTL and testbench
==============================

// Module: fb_addr_gen
// PURPOSE
//  Parametrised frame-buffer read-address generator driven by incoming VGA sync.
//  Tracks Hsync/Vsync and back-porch timing and emits one BRAM pixel address per active clock.
//  Supports horizontal and vertical mirroring, a base-address offset and programmable sync polarity.
//  Sits between the sync timing source and the frame-buffer BRAM read port.
// PARAMETERS
//  HSIZE     640  active pixels per line
//  VSIZE     480  active lines per frame
//  HBP       16   clocks from Hsync deassertion to first active pixel (>=1)
//  VBP       10   Hsync pulses after Vsync deassertion before active line 0 (>=0)
//  ADDR_W    19   address width; all address arithmetic is modulo 2^ADDR_W
//  SYNC_POL  0    asserted level of Hsync/Vsync (0 = active-low)
// PORTS
//  CLK         in   1       pixel clock; Hsync/Vsync are synchronous to it
//  RESET       in   1       asynchronous, active-high reset
//  Hsync       in   1       horizontal sync
//  Vsync       in   1       vertical sync
//  hflip       in   1       mirror columns (sampled at frame start)
//  vflip       in   1       mirror rows (sampled at frame start)
//  base_addr   in   ADDR_W  frame base address (sampled at frame start)
//  addr        out  ADDR_W  pixel address, valid when addr_valid
//  addr_valid  out  1       high for exactly HSIZE consecutive cycles per active line
//  row         out  16      logical active-line index 0..VSIZE-1 (pre-mirror)
//  line_start  out  1       1-cycle pulse coincident with first addr_valid of a line
//  frame_start out  1       1-cycle pulse coincident with first addr_valid of row 0
//  sync_err    out  1       1-cycle pulse on an aborted line or frame
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; latched modes 0; counters 0.
//  - "Asserted" means input == SYNC_POL; edges detected against 1-cycle-delayed copy.
//  - States: IDLE -> VBLANK -> HPORCH -> ACTIVE -> HWAIT -> (HPORCH | DONE).
//  - Any state, Vsync asserted: go VBLANK, latch hflip/vflip/base_addr, clear row/line counters.
//    If previous state was ACTIVE or HWAIT with row<VSIZE-1, pulse sync_err.
//  - VBLANK: count Hsync assertion edges after Vsync deasserts; after VBP of them,
//    the next Hsync deassertion enters HPORCH.
//  - HPORCH: if Hsync first sampled deasserted at edge k, addr_valid is high at edges
//    k+HBP .. k+HBP+HSIZE-1 (registered outputs, no further latency).
//  - ACTIVE: col counts 0..HSIZE-1; after last pixel go HWAIT, or DONE if row==VSIZE-1.
//  - Hsync asserted during ACTIVE: abort line (addr_valid low next cycle), pulse sync_err,
//    row still advances, go HWAIT.
//  - HWAIT: next Hsync deassertion -> HPORCH with row+1.
//  - DONE: further lines ignored (addr_valid stays 0) until Vsync.
//  - Address: erow = vflip ? VSIZE-1-row : row; ecol = hflip ? HSIZE-1-col : col;
//    addr = base_addr + erow*HSIZE + ecol. Computed incrementally (line base register
//    +/-HSIZE per line, +/-1 per pixel); no multiplier.
//  - Mode/base changes mid-frame have no effect until next Vsync.
//  - Reset mid-line: outputs drop to 0 immediately (async); resume at next Vsync.
// TESTING (bench params HSIZE=8 VSIZE=4 HBP=2 VBP=1 ADDR_W=8 SYNC_POL=0)
//  1 No flip, base 0: rows give addr 0..7, 8..15, 16..23, 24..31; frame_start with addr 0.
//  2 vflip=1, base 0x10: row 0 addr 0x28..0x2F, last row 0x10..0x17.
//  3 hflip=1 vflip=1, base 0: first addr 31 descending to 0; line_start each 8-pixel run.
//  4 Base 0xF8, no flip: addr wraps 0xF8..0xFF, 0x00..; addr_valid width exactly 8.
//  5 Hsync asserted after 3 active pixels -> addr_valid drops, sync_err 1 pulse, next line row=1.
//  6 Assert RESET mid-line -> outputs 0 at once; after release, nothing until Vsync, then case 1.

Source files
------------

// File: rtl/fb_addr_gen_if.sv
// Signal bundle between the VGA timing source, fb_addr_gen and the frame-buffer BRAM read port.
// The master side drives sync and frame modes; the slave side returns the pixel address stream.
interface fb_addr_gen_if #(
    parameter int ADDR_W = 19
);
    logic              Hsync;
    logic              Vsync;
    logic              hflip;
    logic              vflip;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic [15:0]       row;
    logic              line_start;
    logic              frame_start;
    logic              sync_err;

    modport master (
        output Hsync, Vsync, hflip, vflip, base_addr,
        input  addr, addr_valid, row, line_start, frame_start, sync_err
    );

    modport slave (
        input  Hsync, Vsync, hflip, vflip, base_addr,
        output addr, addr_valid, row, line_start, frame_start, sync_err
    );
endinterface

// File: rtl/fb_addr_gen.sv
// Frame-buffer read-address generator: follows incoming Hsync/Vsync and emits one BRAM
// address per active pixel, with optional row/column mirroring and a per-frame base offset.
module fb_addr_gen #(
    parameter int HSIZE    = 640,
    parameter int VSIZE    = 480,
    parameter int HBP      = 16,
    parameter int VBP      = 10,
    parameter int ADDR_W   = 19,
    parameter bit SYNC_POL = 1'b0
) (
    input logic          CLK,
    input logic          RESET,
    fb_addr_gen_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        VBLANK,
        HPORCH,
        ACTIVE,
        HWAIT,
        DONE
    } state_t;

    localparam int CW = $clog2(HSIZE + 1);
    localparam int PW = $clog2(HBP + 1);
    localparam int VW = $clog2(VBP + 2);

    localparam logic [ADDR_W-1:0] LINE_STEP    = ADDR_W'(HSIZE);
    localparam logic [ADDR_W-1:0] LAST_COL     = ADDR_W'(HSIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_OFS = ADDR_W'((VSIZE - 1) * HSIZE);

    // Address moves by +/-delta, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] wrap_step(input logic [ADDR_W-1:0] a,
                                                    input logic [ADDR_W-1:0] delta,
                                                    input logic              neg);
        return neg ? (a - delta) : (a + delta);
    endfunction

    state_t            state_p1, state_n;
    logic              hs_act_p0;
    logic [CW-1:0]     col_p1, col_n;
    logic [PW-1:0]     pcnt_p1, pcnt_n;
    logic [VW-1:0]     vcnt_p1, vcnt_n;
    logic [15:0]       row_p1, row_n;
    logic [ADDR_W-1:0] lbase_p1, lbase_n;
    logic [ADDR_W-1:0] addr_p1, addr_n;
    logic              hflip_p1, hflip_n;
    logic              vflip_p1, vflip_n;
    logic              vld_p1, vld_n;
    logic              ls_p1, ls_n;
    logic              fs_p1, fs_n;
    logic              err_p1, err_n;

    logic hs_act, vs_act, hs_rise, hs_fall, last_row, last_col;

    assign hs_act   = (bus.Hsync == SYNC_POL);
    assign vs_act   = (bus.Vsync == SYNC_POL);
    assign hs_rise  = hs_act && !hs_act_p0;
    assign hs_fall  = !hs_act && hs_act_p0;
    assign last_row = (row_p1 == 16'(VSIZE - 1));
    assign last_col = (col_p1 == CW'(HSIZE - 1));

    always_comb begin
        state_n = state_p1;
        col_n   = col_p1;
        pcnt_n  = pcnt_p1;
        vcnt_n  = vcnt_p1;
        row_n   = row_p1;
        lbase_n = lbase_p1;
        addr_n  = addr_p1;
        hflip_n = hflip_p1;
        vflip_n = vflip_p1;
        vld_n   = 1'b0;
        ls_n    = 1'b0;
        fs_n    = 1'b0;
        err_n   = 1'b0;

        if (vs_act) begin
            // Frame modes are captured only here, so mid-frame changes wait for the next Vsync.
            state_n = VBLANK;
            hflip_n = bus.hflip;
            vflip_n = bus.vflip;
            lbase_n = bus.base_addr + (bus.vflip ? LAST_ROW_OFS : '0);
            row_n   = '0;
            col_n   = '0;
            pcnt_n  = '0;
            vcnt_n  = '0;
            err_n   = (state_p1 == ACTIVE) || ((state_p1 == HWAIT) && !last_row);
        end else begin
            case (state_p1)
                IDLE, DONE: begin
                end
                VBLANK: begin
                    if (hs_rise && (vcnt_p1 != VW'(VBP))) begin
                        vcnt_n = vcnt_p1 + VW'(1);
                    end else if (hs_fall && (vcnt_p1 == VW'(VBP))) begin
                        state_n = HPORCH;
                        pcnt_n  = '0;
                    end
                end
                HPORCH: begin
                    if (pcnt_p1 == PW'(HBP - 1)) begin
                        state_n = ACTIVE;
                        col_n   = '0;
                        vld_n   = 1'b1;
                        ls_n    = 1'b1;
                        fs_n    = (row_p1 == '0);
                        addr_n  = lbase_p1 + (hflip_p1 ? LAST_COL : '0);
                    end else begin
                        pcnt_n = pcnt_p1 + PW'(1);
                    end
                end
                ACTIVE: begin
                    if (last_col) begin
                        state_n = last_row ? DONE : HWAIT;
                    end else if (hs_act) begin
                        // Early Hsync truncates the line; the row still counts as consumed.
                        err_n   = 1'b1;
                        state_n = HWAIT;
                    end else begin
                        vld_n  = 1'b1;
                        col_n  = col_p1 + CW'(1);
                        addr_n = wrap_step(addr_p1, ADDR_W'(1), hflip_p1);
                    end
                end
                HWAIT: begin
                    if (hs_fall) begin
                        if (last_row) begin
                            state_n = DONE;
                        end else begin
                            state_n = HPORCH;
                            pcnt_n  = '0;
                            row_n   = row_p1 + 16'd1;
                            lbase_n = wrap_step(lbase_p1, LINE_STEP, vflip_p1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_p1  <= IDLE;
            hs_act_p0 <= 1'b0;
            col_p1    <= '0;
            pcnt_p1   <= '0;
            vcnt_p1   <= '0;
            row_p1    <= '0;
            lbase_p1  <= '0;
            addr_p1   <= '0;
            hflip_p1  <= 1'b0;
            vflip_p1  <= 1'b0;
            vld_p1    <= 1'b0;
            ls_p1     <= 1'b0;
            fs_p1     <= 1'b0;
            err_p1    <= 1'b0;
        end else begin
            state_p1  <= state_n;
            hs_act_p0 <= hs_act;
            col_p1    <= col_n;
            pcnt_p1   <= pcnt_n;
            vcnt_p1   <= vcnt_n;
            row_p1    <= row_n;
            lbase_p1  <= lbase_n;
            addr_p1   <= addr_n;
            hflip_p1  <= hflip_n;
            vflip_p1  <= vflip_n;
            vld_p1    <= vld_n;
            ls_p1     <= ls_n;
            fs_p1     <= fs_n;
            err_p1    <= err_n;
        end
    end

    assign bus.addr        = addr_p1;
    assign bus.addr_valid  = vld_p1;
    assign bus.row         = row_p1;
    assign bus.line_start  = ls_p1;
    assign bus.frame_start = fs_p1;
    assign bus.sync_err    = err_p1;
endmodule

// File: tb/tb_fb_addr_gen.sv
// Bench for fb_addr_gen: drives randomized VGA-style sync frames and predicts every output cycle
// from the frame geometry (row/column arithmetic) rather than from the design's state machine.
module tb_fb_addr_gen;
    localparam int HSIZE    = 8;
    localparam int VSIZE    = 4;
    localparam int HBP      = 2;
    localparam int VBP      = 1;
    localparam int ADDR_W   = 8;
    localparam bit SYNC_POL = 1'b0;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    bit fr_hf;
    bit fr_vf;
    int fr_base;

    fb_addr_gen_if #(.ADDR_W(ADDR_W)) dif ();

    fb_addr_gen #(
        .HSIZE   (HSIZE),
        .VSIZE   (VSIZE),
        .HBP     (HBP),
        .VBP     (VBP),
        .ADDR_W  (ADDR_W),
        .SYNC_POL(SYNC_POL)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (dif.slave)
    );

    always #5 CLK = ~CLK;

    function automatic int exp_addr(input int r, input int c);
        int er;
        int ec;
        er = fr_vf ? (VSIZE - 1 - r) : r;
        ec = fr_hf ? (HSIZE - 1 - c) : c;
        return (fr_base + er * HSIZE + ec) % 256;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, dif.addr_valid, 0);
        chk({tag, "_addr"}, dif.addr, 0);
        chk({tag, "_row"}, dif.row, 0);
        chk({tag, "_line_start"}, dif.line_start, 0);
        chk({tag, "_frame_start"}, dif.frame_start, 0);
        chk({tag, "_sync_err"}, dif.sync_err, 0);
    endtask

    task automatic tick_chk(input bit v, input int a, input int r,
                            input bit ls, input bit fs, input bit er);
        step();
        chk("addr_valid", dif.addr_valid, v);
        chk("line_start", dif.line_start, ls);
        chk("frame_start", dif.frame_start, fs);
        chk("sync_err", dif.sync_err, er);
        if (v) begin
            chk("addr", dif.addr, a);
            chk("row", dif.row, r);
        end
    endtask

    // One line: Hsync pulse, back porch, HSIZE pixels (or none), front porch.
    task automatic run_line(input int r, input bit act, input int abort_at, input int rst_at);
        int hs_w;
        int fp;
        hs_w = $urandom_range(1, 3);
        for (int i = 0; i < hs_w; i++) begin
            dif.Hsync = SYNC_POL;
            tick_chk(0, 0, 0, 0, 0, 0);
        end
        dif.Hsync = ~SYNC_POL;
        tick_chk(0, 0, 0, 0, 0, 0);
        for (int i = 1; i < HBP; i++) tick_chk(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < HSIZE; c++) begin
            if (act && c == abort_at) begin
                dif.Hsync = SYNC_POL;
                tick_chk(0, 0, 0, 0, 0, 1);
                return;
            end
            if (act && c == rst_at) begin
                RESET = 1'b1;
                #1;
                chk_zero("rst_async");
                step();
                step();
                RESET = 1'b0;
                return;
            end
            tick_chk(act, exp_addr(r, c), r, act && c == 0, act && c == 0 && r == 0, 0);
        end
        fp = $urandom_range(1, 3);
        for (int i = 0; i < fp; i++) tick_chk(0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_frame(input bit hf, input bit vf, input logic [7:0] base,
                             input bit exp_err, input int n_rows, input int abort_row);
        int vw;
        int gap;
        fr_hf   = hf;
        fr_vf   = vf;
        fr_base = int'(base);
        dif.hflip     = hf;
        dif.vflip     = vf;
        dif.base_addr = base;
        dif.Hsync     = ~SYNC_POL;
        vw = $urandom_range(1, 3);
        for (int i = 0; i < vw; i++) begin
            dif.Vsync = SYNC_POL;
            tick_chk(0, 0, 0, 0, 0, (i == 0) && exp_err);
        end
        dif.Vsync     = ~SYNC_POL;
        dif.hflip     = 1'($urandom);
        dif.vflip     = 1'($urandom);
        dif.base_addr = 8'($urandom);
        gap = $urandom_range(1, 3);
        for (int i = 0; i < gap; i++) tick_chk(0, 0, 0, 0, 0, 0);
        for (int r = 0; r < n_rows; r++) run_line(r, 1, (r == abort_row) ? 3 : -1, -1);
        if (n_rows == VSIZE) run_line(0, 0, -1, -1);
    endtask

    initial begin
        dif.Hsync     = ~SYNC_POL;
        dif.Vsync     = ~SYNC_POL;
        dif.hflip     = 1'b0;
        dif.vflip     = 1'b0;
        dif.base_addr = '0;
        RESET = 1'b1;
        #2;
        chk_zero("reset");
        step();
        step();
        chk_zero("reset_held");
        RESET = 1'b0;
        step();
        chk_zero("idle");
        run_line(0, 0, -1, -1);

        run_frame(1'b0, 1'b0, 8'h00, 1'b0, VSIZE, -1);
        run_frame(1'b0, 1'b1, 8'h10, 1'b0, VSIZE, -1);
        run_frame(1'b1, 1'b1, 8'h00, 1'b0, VSIZE, -1);
        run_frame(1'b0, 1'b0, 8'hF8, 1'b0, VSIZE, -1);
        run_frame(1'b0, 1'b0, 8'h00, 1'b0, VSIZE, 0);

        for (int i = 0; i < 4; i++)
            run_frame(1'($urandom), 1'($urandom), 8'($urandom), 1'b0, VSIZE, -1);

        run_frame(1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 2, -1);
        run_frame(1'($urandom), 1'($urandom), 8'($urandom), 1'b1, VSIZE, -1);

        run_frame(1'b0, 1'b0, 8'h00, 1'b0, 0, -1);
        run_line(0, 1, -1, 4);
        run_line(0, 0, -1, -1);
        run_frame(1'b0, 1'b0, 8'h00, 1'b0, VSIZE, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
